// File: rtl/i2s_tx_serializer.sv
// Stereo I2S transmit serializer. bclk/lrck are sampled as ordinary data in the
// mclki domain; one stereo frame per valid/ready handshake is shifted out MSB first.
module i2s_tx_serializer (
    input  logic        mclki,
    input  logic        rst,
    input  logic        enable,
    input  logic        bclk,
    input  logic        lrck,
    input  logic [5:0]  word_width,
    input  logic [31:0] s_tdata_l,
    input  logic [31:0] s_tdata_r,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic        sdata,
    output logic        underrun,
    output logic        active
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        bclk_q;
    logic        lrck_s_q, lrck_s_d;
    logic        full_q, full_d;
    logic        sdata_q, sdata_d;
    logic        underrun_q, underrun_d;
    logic        ww16_q, ww16_d;
    logic [31:0] hold_l_q, hold_l_d;
    logic [31:0] hold_r_q, hold_r_d;
    logic [31:0] shreg_q, shreg_d;
    logic [31:0] right_q, right_d;

    logic        bfall;
    logic        ev_left;
    logic        ev_right;
    logic        clear;
    logic        hs;
    logic        load_l;
    logic        load_r;
    logic        shift_en;

    assign bfall    = bclk_q & ~bclk;
    assign ev_left  = bfall & ~lrck & lrck_s_q;
    assign ev_right = bfall & lrck & ~lrck_s_q;
    assign clear    = ~enable | (state_q == IDLE);
    assign hs       = s_tvalid & s_tready;

    assign sdata    = sdata_q;
    assign underrun = underrun_q;

    always_ff @(posedge mclki or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = SYNC;
                SYNC:    if (ev_left) state_d = RUN;
                RUN:     state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // SYNC only reacts to a left start; right starts are ignored until RUN.
    always_comb begin
        s_tready = 1'b0;
        active   = 1'b0;
        load_l   = 1'b0;
        load_r   = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            SYNC: begin
                s_tready = enable & ~full_q;
                load_l   = enable & ev_left;
            end
            RUN: begin
                s_tready = enable & ~full_q;
                active   = 1'b1;
                load_l   = enable & ev_left;
                load_r   = enable & ev_right;
                shift_en = enable & bfall;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        lrck_s_d   = lrck_s_q;
        full_d     = full_q;
        sdata_d    = sdata_q;
        underrun_d = 1'b0;
        ww16_d     = ww16_q;
        hold_l_d   = hold_l_q;
        hold_r_d   = hold_r_q;
        shreg_d    = shreg_q;
        right_d    = right_q;

        if (clear) begin
            lrck_s_d = 1'b1;
            full_d   = 1'b0;
            sdata_d  = 1'b0;
            shreg_d  = '0;
            right_d  = '0;
        end else begin
            if (bfall) begin
                lrck_s_d = lrck;
            end
            if (hs) begin
                hold_l_d = s_tdata_l;
                hold_r_d = s_tdata_r;
                full_d   = 1'b1;
            end
            // A frame arriving in the same cycle as L waits in hold for the next L.
            if (load_l) begin
                ww16_d = (word_width == 6'd16);
                if (full_q) begin
                    shreg_d = hold_l_q;
                    right_d = hold_r_q;
                    full_d  = 1'b0;
                end else begin
                    shreg_d    = '0;
                    right_d    = '0;
                    underrun_d = 1'b1;
                end
            end else if (load_r) begin
                shreg_d = right_q;
            end else if (shift_en) begin
                shreg_d = {shreg_q[30:0], 1'b0};
            end
            // The outgoing bit is always the old MSB, giving the one-bclk I2S delay.
            if (shift_en) begin
                sdata_d = shreg_q[31];
            end
        end
    end

    always_ff @(posedge mclki or posedge rst) begin
        if (rst) begin
            bclk_q     <= 1'b0;
            lrck_s_q   <= 1'b1;
            full_q     <= 1'b0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
            ww16_q     <= 1'b0;
        end else begin
            bclk_q     <= bclk;
            lrck_s_q   <= lrck_s_d;
            full_q     <= full_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
            ww16_q     <= ww16_d;
        end
    end

    always_ff @(posedge mclki) begin
        hold_l_q <= hold_l_d;
        hold_r_q <= hold_r_d;
        shreg_q  <= shreg_d;
        right_q  <= right_d;
    end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: models the clock divider and a frame
// source, reassembles received slot words and compares against hand-set values.
module tb_i2s_tx_serializer;
    logic        mclki = 1'b0;
    logic        rst;
    logic        enable;
    logic        bclk;
    logic        lrck;
    logic [5:0]  word_width;
    logic [31:0] s_tdata_l;
    logic [31:0] s_tdata_r;
    logic        s_tvalid;
    logic        s_tready;
    logic        sdata;
    logic        underrun;
    logic        active;

    int n_tests = 0;
    int n_fail  = 0;
    int ur_cnt  = 0;
    int rdy_cnt = 0;
    int hs_cnt  = 0;
    int feed_idx = 0;
    int feed_n   = 0;
    logic [31:0] fl [0:63];
    logic [31:0] fr [0:63];

    int          slot_w;
    int          bit_idx;
    logic [31:0] rx_sr;
    logic [31:0] rx_q [$];

    i2s_tx_serializer dut (
        .mclki      (mclki),
        .rst        (rst),
        .enable     (enable),
        .bclk       (bclk),
        .lrck       (lrck),
        .word_width (word_width),
        .s_tdata_l  (s_tdata_l),
        .s_tdata_r  (s_tdata_r),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .sdata      (sdata),
        .underrun   (underrun),
        .active     (active)
    );

    always #5 mclki = ~mclki;

    always @(negedge mclki) begin
        if (underrun) ur_cnt <= ur_cnt + 1;
        if (s_tready) rdy_cnt <= rdy_cnt + 1;
        if (s_tready && s_tvalid) hs_cnt <= hs_cnt + 1;
    end

    // Frame source: presents fl/fr[feed_idx] while feed_idx < feed_n.
    initial begin
        logic hs_f;
        s_tvalid  = 1'b0;
        s_tdata_l = '0;
        s_tdata_r = '0;
        forever begin
            @(negedge mclki);
            hs_f = s_tvalid && s_tready;
            @(posedge mclki);
            #2;
            if (hs_f) feed_idx++;
            if (feed_idx < feed_n) begin
                s_tvalid  = 1'b1;
                s_tdata_l = fl[feed_idx];
                s_tdata_r = fr[feed_idx];
            end else begin
                s_tvalid = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input int i);
        if (i < rx_q.size()) return rx_q[i];
        return 32'hDEAD_BEEF;
    endfunction

    // One bclk period: falling half (lrck may toggle) then rising half; sdata
    // is captured just before bclk rises, as an I2S receiver would.
    task automatic bit_period();
        logic toggled;
        toggled = 1'b0;
        if (bit_idx == slot_w) begin
            lrck    = ~lrck;
            bit_idx = 0;
            toggled = 1'b1;
        end
        bit_idx++;
        bclk = 1'b0;
        repeat (4) @(posedge mclki);
        #1;
        rx_sr = {rx_sr[30:0], sdata};
        if (toggled) rx_q.push_back(rx_sr << (32 - slot_w));
        bclk = 1'b1;
        repeat (4) @(posedge mclki);
        #1;
    endtask

    task automatic gen(input int n);
        repeat (n) bit_period();
    endtask

    task automatic restart_divider();
        bclk    = 1'b1;
        lrck    = 1'b1;
        bit_idx = 0;
        rx_sr   = '0;
        rx_q.delete();
    endtask

    task automatic start_test(input int sw, input logic [5:0] ww);
        feed_n     = feed_idx;
        rst        = 1'b1;
        enable     = 1'b0;
        word_width = ww;
        slot_w     = sw;
        restart_divider();
        repeat (2) @(posedge mclki);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge mclki);
        #1;
        feed_n = feed_idx;
    endtask

    task automatic queue_frame(input logic [31:0] l, input logic [31:0] r);
        fl[feed_n] = l;
        fr[feed_n] = r;
        feed_n++;
    endtask

    task automatic go();
        enable = 1'b1;
        repeat (4) @(posedge mclki);
        #1;
    endtask

    initial begin
        int ur0;
        int rdy0;
        int hs0;

        // Reset with enable already high: outputs must still be at reset values.
        rst = 1'b1;
        enable = 1'b1;
        word_width = 6'd32;
        slot_w = 32;
        restart_divider();
        repeat (3) @(posedge mclki);
        #1;
        check_eq("rst_sdata", sdata, 0);
        check_eq("rst_tready", s_tready, 0);
        check_eq("rst_underrun", underrun, 0);
        check_eq("rst_active", active, 0);
        rst = 1'b0;
        @(posedge mclki);
        #1;
        check_eq("sync_tready", s_tready, 1);
        check_eq("sync_active", active, 0);

        // 32-bit slots, two frames, then an empty left slot.
        start_test(32, 6'd32);
        queue_frame(32'hA500_0001, 32'h8000_0003);
        queue_frame(32'h0F0F_0F0F, 32'h1234_5678);
        ur0 = ur_cnt;
        go();
        check_eq("A_sync_active", active, 0);
        gen(160);
        check_eq("A_no_underrun", ur_cnt - ur0, 0);
        check_eq("A_active", active, 1);
        gen(1);
        check_eq("A_nwords", rx_q.size(), 5);
        check_eq("A_sync_word", word_at(0), 32'h0);
        check_eq("A_L0", word_at(1), 32'hA500_0001);
        check_eq("A_R0", word_at(2), 32'h8000_0003);
        check_eq("A_L1", word_at(3), 32'h0F0F_0F0F);
        check_eq("A_R1", word_at(4), 32'h1234_5678);
        check_eq("A_underrun_end", ur_cnt - ur0, 1);

        // 16-bit slots.
        start_test(16, 6'd16);
        queue_frame(32'h1234_0000, 32'hFFFF_0000);
        queue_frame(32'hBEEF_0000, 32'h0001_0000);
        ur0 = ur_cnt;
        go();
        gen(81);
        check_eq("B_nwords", rx_q.size(), 5);
        check_eq("B_sync_word", word_at(0), 32'h0);
        check_eq("B_L0", word_at(1), 32'h1234_0000);
        check_eq("B_R0", word_at(2), 32'hFFFF_0000);
        check_eq("B_L1", word_at(3), 32'hBEEF_0000);
        check_eq("B_R1", word_at(4), 32'h0001_0000);
        check_eq("B_underrun", ur_cnt - ur0, 1);

        // No frames at all: one underrun cycle per left slot.
        start_test(32, 6'd32);
        ur0 = ur_cnt;
        go();
        check_eq("C_tready", s_tready, 1);
        gen(129);
        check_eq("C_underrun_cycles", ur_cnt - ur0, 2);
        check_eq("C_active", active, 1);
        check_eq("C_L_zero", word_at(1), 32'h0);
        check_eq("C_R_zero", word_at(2), 32'h0);
        check_eq("C_tready_end", s_tready, 1);

        // Continuous valid with incrementing data.
        start_test(32, 6'd32);
        for (int i = 0; i < 10; i++) queue_frame(32'h1000_0000 + i, 32'h2000_0000 + i);
        ur0  = ur_cnt;
        rdy0 = rdy_cnt;
        hs0  = hs_cnt;
        go();
        gen(545);
        check_eq("D_underrun", ur_cnt - ur0, 0);
        check_eq("D_nwords", rx_q.size(), 17);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("D_L%0d", i), word_at(1 + 2 * i), 32'h1000_0000 + i);
            check_eq($sformatf("D_R%0d", i), word_at(2 + 2 * i), 32'h2000_0000 + i);
        end
        check_eq("D_handshakes", hs_cnt - hs0, 10);
        check_eq("D_tready_cycles", rdy_cnt - rdy0, 10);

        // Enable drop mid-left-slot, then restart with a fresh frame.
        start_test(32, 6'd32);
        queue_frame(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        queue_frame(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        go();
        gen(42);
        check_eq("E_pre_sdata", sdata, 1);
        enable = 1'b0;
        @(posedge mclki);
        #1;
        check_eq("E_off_sdata", sdata, 0);
        check_eq("E_off_tready", s_tready, 0);
        check_eq("E_off_active", active, 0);
        repeat (3) @(posedge mclki);
        #1;
        restart_divider();
        queue_frame(32'h3C3C_3C3C, 32'hC3C3_C3C3);
        go();
        gen(97);
        check_eq("E_resync_zero", word_at(0), 32'h0);
        check_eq("E_new_L", word_at(1), 32'h3C3C_3C3C);
        check_eq("E_new_R", word_at(2), 32'hC3C3_C3C3);
        check_eq("E_active", active, 1);

        // Asynchronous reset between clock edges.
        start_test(32, 6'd32);
        queue_frame(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        go();
        gen(42);
        check_eq("F_pre_sdata", sdata, 1);
        check_eq("F_pre_tready", s_tready, 1);
        check_eq("F_pre_active", active, 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("F_rst_sdata", sdata, 0);
        check_eq("F_rst_tready", s_tready, 0);
        check_eq("F_rst_active", active, 0);
        check_eq("F_rst_underrun", underrun, 0);
        repeat (2) @(posedge mclki);
        #1;
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
